// File: rtl/popcount_arb_pkg.sv
// Shared types and width helpers for the popcount arbiter.
package popcount_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: search starts one past last_served and wraps.
module rr_arbiter
  import popcount_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_served,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid
);

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    w_idx   = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = IW'((int'(last_served) + k) % NUM_REQ);
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_idx   = w_pos;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign gnt_onehot[gi] = w_found && (w_idx == IW'(gi));
    end
  endgenerate

  assign gnt_idx   = w_idx;
  assign gnt_valid = w_found;

endmodule

// File: rtl/popcount_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared bit-count datapath.
// Optional WAIT timeout abort enabled by defining POPCOUNT_ARB_TIMEOUT_EN.
module popcount_arbiter
  import popcount_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  parameter  int TIMEOUT = 64,
  localparam int CW      = cnt_width(WIDTH),
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     dp_go,
  output logic [WIDTH-1:0]         dp_data,
  input  logic                     dp_done,
  input  logic [CW-1:0]            dp_count,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IW-1:0]            resp_id,
  output logic [CW-1:0]            resp_count,
  output logic                     resp_err
);

  state_t               r_state;
  state_t               w_state_next;
  logic [IW-1:0]        r_last;
  logic [WIDTH-1:0]     r_data;
  logic                 r_dp_go;
  logic [IW-1:0]        r_resp_id;
  logic [CW-1:0]        r_resp_count;
  logic [NUM_REQ-1:0]   w_arb_onehot;
  logic [IW-1:0]        w_arb_idx;
  logic                 w_arb_valid;
  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req         (req),
    .last_served (r_last),
    .gnt_onehot  (w_arb_onehot),
    .gnt_idx     (w_arb_idx),
    .gnt_valid   (w_arb_valid)
  );

  assign w_sel_data = req_data[int'(w_arb_idx)*WIDTH +: WIDTH];

`ifdef POPCOUNT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait_cnt;
  logic          r_resp_err;

  // Counter sits at 0 on WAIT entry, so WAIT cycle k sees r_wait_cnt == k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !dp_done && (r_wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_err <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (dp_done) begin
        r_resp_err <= 1'b0;
      end else if (w_timeout) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  assign resp_err = r_resp_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_arb_valid) w_state_next = ST_ISSUE;
      ST_ISSUE:   w_state_next = ST_WAIT;
      ST_WAIT:    if (dp_done || w_timeout) w_state_next = ST_RESPOND;
      ST_RESPOND: if (resp_ready) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last       <= IW'(NUM_REQ - 1);
      r_data       <= '0;
      r_dp_go      <= 1'b0;
      r_resp_id    <= '0;
      r_resp_count <= '0;
    end else begin
      // dp_go is registered off ISSUE, landing two cycles after the grant.
      r_dp_go <= (r_state == ST_ISSUE);
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_resp_id <= w_arb_idx;
            r_data    <= w_sel_data;
          end
        end
        ST_WAIT: begin
          if (dp_done) begin
            r_resp_count <= dp_count;
          end else if (w_timeout) begin
            r_resp_count <= '0;
          end
        end
        ST_RESPOND: begin
          if (resp_ready) r_last <= r_resp_id;
        end
        default: ;
      endcase
    end
  end

  // Grant is the only output with a combinational path from req; rst_n gates it.
  always_comb begin
    gnt        = (rst_n && (r_state == ST_IDLE)) ? w_arb_onehot : '0;
    resp_valid = (r_state == ST_RESPOND);
  end

  assign dp_go      = r_dp_go;
  assign dp_data    = r_data;
  assign resp_id    = r_resp_id;
  assign resp_count = r_resp_count;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed self-checking bench for popcount_arbiter (NUM_REQ=4, WIDTH=8).
module tb_popcount_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int CW      = 4;
  localparam int IW      = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     dp_go;
  logic [WIDTH-1:0]         dp_data;
  logic                     dp_done;
  logic [CW-1:0]            dp_count;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IW-1:0]            resp_id;
  logic [CW-1:0]            resp_count;
  logic                     resp_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Slices 3..0 = FF, 81, F0, 07 -> bit counts 8, 2, 4, 3
  localparam logic [31:0] DATA_A = 32'hFF81F007;
  localparam logic [31:0] DATA_Z = 32'hFF81F000;

  always #5 clk = ~clk;

  popcount_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .dp_go      (dp_go),
    .dp_data    (dp_data),
    .dp_done    (dp_done),
    .dp_count   (dp_count),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full transaction: gnt now, dp_go two cycles later, response next cycle.
  task automatic serve(input logic [3:0] reqv, input logic [31:0] data, input int id,
                       input logic [3:0] cnt, input bit hold, input int stall);
    logic [3:0] exp_gnt;
    logic [7:0] exp_byte;
    exp_gnt  = 4'b0001 << id;
    exp_byte = data[id*8 +: 8];
    req      = reqv;
    req_data = data;
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    tick();
    check("gnt_pulse", 32'(gnt), 0);
    check("dp_go_early", 32'(dp_go), 0);
    if (!hold) req = '0;
    tick();
    check("dp_go", 32'(dp_go), 1);
    check("dp_data", 32'(dp_data), 32'(exp_byte));
    check("valid_early", 32'(resp_valid), 0);
    dp_done  = 1'b1;
    dp_count = cnt;
    tick();
    dp_done = 1'b0;
    check("dp_go_pulse", 32'(dp_go), 0);
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_id", 32'(resp_id), 32'(id));
    check("resp_count", 32'(resp_count), 32'(cnt));
    check("resp_err", 32'(resp_err), 0);
    for (int s = 0; s < stall; s++) begin
      dp_done  = 1'b1;
      dp_count = 4'hF;
      tick();
      check("stall_valid", 32'(resp_valid), 1);
      check("stall_id", 32'(resp_id), 32'(id));
      check("stall_count", 32'(resp_count), 32'(cnt));
      check("stall_gnt", 32'(gnt), 0);
    end
    dp_done    = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("valid_drop", 32'(resp_valid), 0);
    $display("txn: req=%b id=%0d count=%0d stall=%0d", reqv, id, cnt, stall);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_dp_go"}, 32'(dp_go), 0);
    check({tag, "_dp_data"}, 32'(dp_data), 0);
    check({tag, "_valid"}, 32'(resp_valid), 0);
    check({tag, "_id"}, 32'(resp_id), 0);
    check({tag, "_count"}, 32'(resp_count), 0);
    check({tag, "_err"}, 32'(resp_err), 0);
  endtask

  initial begin
    int seen;
    rst_n      = 1'b0;
    req        = '0;
    req_data   = '0;
    dp_done    = 1'b0;
    dp_count   = '0;
    resp_ready = 1'b0;
    repeat (2) tick();
    req = 4'b1111;
    #1;
    check_reset_outputs("rst");
    req   = '0;
    rst_n = 1'b1;
    tick();

    // Fairness with all requests held: 0,1,2,3,0
    serve(4'b1111, DATA_A, 0, 4'd3, 1'b1, 0);
    serve(4'b1111, DATA_A, 1, 4'd4, 1'b1, 0);
    serve(4'b1111, DATA_A, 2, 4'd2, 1'b1, 0);
    serve(4'b1111, DATA_A, 3, 4'd8, 1'b1, 0);
    serve(4'b1111, DATA_A, 0, 4'd3, 1'b0, 0);

    // Single request, F0 -> 4
    serve(4'b0010, DATA_A, 1, 4'd4, 1'b0, 0);

    // Backpressure: 5 stalled cycles, stray dp_done ignored, no new grant
    serve(4'b1000, DATA_A, 3, 4'd8, 1'b1, 5);

    // Zero operand
    serve(4'b0001, DATA_Z, 0, 4'd0, 1'b0, 0);

    // Datapath never answers
    req = 4'b1111;
    #1;
    check("to_gnt", 32'(gnt), 32'(4'b0010));
    tick();
    req = '0;
    tick();
    check("to_dp_go", 32'(dp_go), 1);
`ifdef POPCOUNT_ARB_TIMEOUT_EN
    seen = 0;
    while (!resp_valid && seen < 100) begin
      tick();
      seen++;
    end
    check("timeout_cycles", 32'(seen), 64);
    check("timeout_err", 32'(resp_err), 1);
    check("timeout_count", 32'(resp_count), 0);
    check("timeout_id", 32'(resp_id), 1);
    $display("txn: timeout id=%0d after %0d wait cycles", resp_id, seen);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req = 4'b1111;
    #1;
    check("to2_gnt", 32'(gnt), 32'(4'b0100));
    tick();
    req = '0;
    tick();
    tick();
`else
    seen = 0;
    repeat (200) begin
      tick();
      if (resp_valid) seen++;
    end
    check("no_timeout_valid", 32'(seen), 0);
    $display("txn: no timeout, WAIT held 200 cycles");
`endif

    // Reset in WAIT with all requests present
    req   = 4'b1111;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'(4'b0001));
    serve(4'b1111, DATA_A, 0, 4'd3, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
